// File: rtl/wb_stage.sv
// Writeback stage: merges ALU and load results through a DEPTH-entry FIFO into one register-file write port.
// Optional WB_FWD_EN macro adds read-data forwarding from pending writes to the decode stage.
module wb_stage #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        reg_wr,
    output logic [4:0]  r2,
    output logic [31:0] data2,
    input  logic [4:0]  rf_r0,
    input  logic [4:0]  rf_r1,
    input  logic [31:0] rf_data0,
    input  logic [31:0] rf_data1,
    output logic [31:0] fwd_data0,
    output logic [31:0] fwd_data1
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [4:0]    q_rd   [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;

    logic        not_full, alu_fire, mem_fire, enq, deq;
    logic [4:0]  enq_rd;
    logic [31:0] enq_data;

    assign not_full  = (count < DEPTH_C);
    assign alu_ready = not_full;
    assign mem_ready = not_full && !alu_valid;
    assign alu_fire  = alu_valid && alu_ready;
    assign mem_fire  = mem_valid && mem_ready;
    assign deq       = (count != '0);

    // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        enq_rd   = mem_rd;
        enq_data = mem_data;
        if (alu_fire) begin
            enq_rd   = alu_rd;
            enq_data = alu_data;
        end
    end

    // Writes to x0 are handshaken normally but never occupy a slot.
    assign enq = (alu_fire || mem_fire) && (enq_rd != 5'd0);

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            reg_wr <= 1'b0;
            r2     <= '0;
            data2  <= '0;
        end else begin
            if (deq) begin
                reg_wr <= 1'b1;
                r2     <= q_rd[rd_ptr];
                data2  <= q_data[rd_ptr];
                rd_ptr <= rd_ptr + PW'(1);
            end else begin
                reg_wr <= 1'b0;
            end
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the entry storage is not reset; count gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_rd[wr_ptr]   <= enq_rd;
            q_data[wr_ptr] <= enq_data;
        end
    end

`ifdef WB_FWD_EN
    // Scan oldest to newest so the last match (the newest pending write) wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        fwd_data0 = rf_data0;
        fwd_data1 = rf_data1;
        if (reg_wr && r2 == rf_r0) fwd_data0 = data2;
        if (reg_wr && r2 == rf_r1) fwd_data1 = data2;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count) begin
                if (q_rd[idx] == rf_r0) fwd_data0 = q_data[idx];
                if (q_rd[idx] == rf_r1) fwd_data1 = q_data[idx];
            end
        end
        if (rf_r0 == 5'd0) fwd_data0 = '0;
        if (rf_r1 == 5'd0) fwd_data1 = '0;
    end
`else
    assign fwd_data0 = rf_data0;
    assign fwd_data1 = rf_data1;

    // Read addresses only matter when forwarding is built in.
    logic unused_rf_addr;
    assign unused_rf_addr = ^{rf_r0, rf_r1};
`endif

endmodule
